dmem_req_ctrl: RTL

Memory-stage access initiator for the y86cpu data memory. It accepts one 64-bit load or store request at a time from the pipeline's memory stage through a valid/ready handshake and drives the `dmem` address, data and write-enable ports. It captures read data and the `dmem_err` flag, then returns a registered response. On any address error it halts the data path, which raises Y86 status ADR, until reset.

---
 rtl/dmem_req_ctrl_pkg.sv | 22 ++
 rtl/dmem_addr_chk.sv | 26 ++
 rtl/dmem_req_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/dmem_req_ctrl_pkg.sv
// Shared constants for the y86cpu data-memory request controller.
// Optional build macro used by this slice: DMEM_ALIGN_CHECK_EN.
package dmem_req_ctrl_pkg;

    localparam logic [63:0] QWORD         = 64'd8;
    localparam logic [63:0] BYTE          = 64'd1;
    localparam logic [63:0] DATA_MEM_SIZE = 64'd1024;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [2:0] STAT_ADR = 3'd3;

    // Subtraction on the constant side only, so addresses near 2^64 cannot wrap.
    function automatic logic out_of_bounds(input logic [63:0] addr,
                                           input logic [63:0] mem_size);
        return addr > (mem_size - QWORD);
    endfunction

endpackage

// File: rtl/dmem_addr_chk.sv
// Combinational bound and alignment check producing the local address fault.
// Alignment checking is compiled in only when DMEM_ALIGN_CHECK_EN is defined.
module dmem_addr_chk
    import dmem_req_ctrl_pkg::*;
#(
    parameter logic [63:0] MEM_SIZE = DATA_MEM_SIZE,
    parameter logic [63:0] ALIGN    = 64'd8
) (
    input  logic [63:0] addr,
    output logic        fault
);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    logic misaligned;

    always_comb begin
        misaligned = (addr % ALIGN) != '0;
        fault      = out_of_bounds(addr, MEM_SIZE) | (ALIGN_EN & misaligned);
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Memory-stage access initiator: one load/store at a time, registered response,
// sticky halt on address error. Optional macro: DMEM_ALIGN_CHECK_EN.
module dmem_req_ctrl
    import dmem_req_ctrl_pkg::*;
#(
    parameter logic [63:0] MEM_SIZE = DATA_MEM_SIZE,
    parameter logic [63:0] ALIGN    = 64'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        halted,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data,
    output logic        mem_write,
    output logic [63:0] read_addr,
    input  logic [63:0] read_data,
    input  logic        dmem_err
);

    logic [1:0]  state;
    logic        wr_q;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic        chk_fault;
    logic        fault;

    dmem_addr_chk #(
        .MEM_SIZE (MEM_SIZE),
        .ALIGN    (ALIGN)
    ) u_addr_chk (
        .addr  (addr_q),
        .fault (chk_fault)
    );

    assign fault      = dmem_err | chk_fault;
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign halted     = (state == S_HALT);
    assign mem_addr   = addr_q;
    assign read_addr  = addr_q;
    assign mem_data   = data_q;
    // The store is suppressed in the same cycle the fault is seen.
    assign mem_write  = (state == S_ACCESS) & wr_q & ~fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q   <= req_write;
                        addr_q <= req_addr;
                        data_q <= req_wdata;
                        state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    resp_err   <= fault;
                    resp_rdata <= (wr_q | fault) ? '0 : read_data;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= resp_err ? S_HALT : S_IDLE;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
